// File: rtl/ie_operand_stage_reg.sv
// -----------------------------------------------------------------------------
// ie_operand_stage_reg
//
// Purpose
//   ID->IE pipeline register for the rs1 operand path. Captures the ID-stage
//   rs1 operand, PC and destination info. It also decides, at capture time,
//   which source IE_mux1 must select for operand A:
//     00 = registered rs1 value
//     01 = registered PC
//     10 = ALU_out_IM_REG2, forwarded from the instruction now moving to IM
//   Load-use hazards against the held instruction raise hazard_stall_req
//   combinationally and load a bubble into IE.
//
// Configuration
//   FWD_WB_EN : when defined, adds the wb_* ports. A matching write-back
//               result replaces the register-file rs1 value on load whenever
//               neither PC nor IM forwarding is selected.
//
// Ports
//   clk, reset             core clock; synchronous active-high reset
//   stall_IE, flush_IE     hold / bubble controls
//   valid_ID ... use_pc_ID ID-stage instruction fields
//   ALU_out_IM_REG2        IM-stage ALU result (forward source)
//   wb_*                   write-back forward source (FWD_WB_EN only)
//   *_IE_REG1/2, IE_mux1_SEL  registered IE-stage outputs
//   hazard_stall_req       combinational load-use stall request
// -----------------------------------------------------------------------------
module ie_operand_stage_reg #(
   parameter int XLEN = 32,
   parameter int PC_W = 11,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_IE,
   input  logic            flush_IE,
   input  logic            valid_ID,
   input  logic [PC_W-1:0] inst_mem_addr_ID,
   input  logic [XLEN-1:0] rs1_value_ID,
   input  logic [RA_W-1:0] rs1_addr_ID,
   input  logic [RA_W-1:0] rd_addr_ID,
   input  logic            reg_write_ID,
   input  logic            mem_read_ID,
   input  logic            use_pc_ID,
   input  logic [XLEN-1:0] ALU_out_IM_REG2,
`ifdef FWD_WB_EN
   input  logic            wb_reg_write,
   input  logic [RA_W-1:0] wb_rd_addr,
   input  logic [XLEN-1:0] wb_value,
`endif
   output logic            valid_IE_REG2,
   output logic [PC_W-1:0] inst_mem_addr_IE_REG1,
   output logic [XLEN-1:0] rs1_value_IE_REG2,
   output logic [RA_W-1:0] rd_addr_IE_REG2,
   output logic            reg_write_IE_REG2,
   output logic            mem_read_IE_REG2,
   output logic [1:0]      IE_mux1_SEL,
   output logic            hazard_stall_req
);

   typedef enum logic [1:0] {
      SEL_RS1 = 2'b00,
      SEL_PC  = 2'b01,
      SEL_IM  = 2'b10
   } sel_e;

   typedef struct packed {
      logic            valid;
      logic [PC_W-1:0] pc;
      logic [XLEN-1:0] rs1;
      logic [RA_W-1:0] rd;
      logic            reg_write;
      logic            mem_read;
      sel_e            sel;
   } ie_t;

   ie_t  ie_q, ie_d;
   sel_e load_sel;
   logic [XLEN-1:0] load_rs1;
   logic im_match;

   // The held instruction reaches IM next cycle. A load there cannot forward
   // in time, so the consumer must wait; rd=x0 never counts as a producer.
   assign hazard_stall_req = valid_ID & ie_q.valid & ie_q.mem_read
                           & (ie_q.rd != '0) & (ie_q.rd == rs1_addr_ID)
                           & ~use_pc_ID;

   assign im_match = ie_q.valid & ie_q.reg_write & (ie_q.rd != '0)
                   & (ie_q.rd == rs1_addr_ID);

   // Operand-A source and value chosen for a fresh capture.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      load_sel = SEL_RS1;
      load_rs1 = rs1_value_ID;
      if (use_pc_ID) begin
         load_sel = SEL_PC;
      end else if (im_match) begin
         load_sel = SEL_IM;
      end
`ifdef FWD_WB_EN
      // IM forwarding wins; WB only patches the register-file value.
      if ((load_sel == SEL_RS1) && wb_reg_write && (wb_rd_addr != '0)
          && (wb_rd_addr == rs1_addr_ID)) begin
         load_rs1 = wb_value;
      end
`endif
   end

   // Next-state: flush > stall > hazard > load (reset handled in the flop).
   always_comb begin
      ie_d = ie_q;
      if (flush_IE) begin
         ie_d.valid     = 1'b0;
         ie_d.reg_write = 1'b0;
         ie_d.mem_read  = 1'b0;
         ie_d.sel       = SEL_RS1;
      end else if (stall_IE) begin
         // IM gets a bubble while IE stalls, so the forwarded result is only
         // visible now: capture it once and fall back to the rs1 path.
         if (ie_q.sel == SEL_IM) begin
            ie_d.rs1 = ALU_out_IM_REG2;
            ie_d.sel = SEL_RS1;
         end
      end else if (hazard_stall_req) begin
         ie_d.valid     = 1'b0;
         ie_d.reg_write = 1'b0;
         ie_d.mem_read  = 1'b0;
         ie_d.sel       = SEL_RS1;
      end else begin
         ie_d.valid     = valid_ID;
         ie_d.pc        = inst_mem_addr_ID;
         ie_d.rs1       = load_rs1;
         ie_d.rd        = rd_addr_ID;
         ie_d.reg_write = reg_write_ID & valid_ID;
         ie_d.mem_read  = mem_read_ID & valid_ID;
         ie_d.sel       = load_sel;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         ie_q <= '0;
      end else begin
         ie_q <= ie_d;
      end
   end

   assign valid_IE_REG2         = ie_q.valid;
   assign inst_mem_addr_IE_REG1 = ie_q.pc;
   assign rs1_value_IE_REG2     = ie_q.rs1;
   assign rd_addr_IE_REG2       = ie_q.rd;
   assign reg_write_IE_REG2     = ie_q.reg_write;
   assign mem_read_IE_REG2      = ie_q.mem_read;
   assign IE_mux1_SEL           = ie_q.sel;

endmodule

// File: tb/tb_ie_operand_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_ie_operand_stage_reg
//   Directed scenarios followed by randomized traffic, compared against a
//   behavioural model of the IE operand register.
// -----------------------------------------------------------------------------
module tb_ie_operand_stage_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall_IE = 1'b0;
   logic        flush_IE = 1'b0;
   logic        valid_ID = 1'b0;
   logic [10:0] inst_mem_addr_ID = '0;
   logic [31:0] rs1_value_ID = '0;
   logic [4:0]  rs1_addr_ID = '0;
   logic [4:0]  rd_addr_ID = '0;
   logic        reg_write_ID = 1'b0;
   logic        mem_read_ID = 1'b0;
   logic        use_pc_ID = 1'b0;
   logic [31:0] ALU_out_IM_REG2 = '0;
   logic        wb_reg_write = 1'b0;
   logic [4:0]  wb_rd_addr = '0;
   logic [31:0] wb_value = '0;

   logic        valid_IE_REG2;
   logic [10:0] inst_mem_addr_IE_REG1;
   logic [31:0] rs1_value_IE_REG2;
   logic [4:0]  rd_addr_IE_REG2;
   logic        reg_write_IE_REG2;
   logic        mem_read_IE_REG2;
   logic [1:0]  IE_mux1_SEL;
   logic        hazard_stall_req;

   int n_checks = 0;
   int n_fail   = 0;
   bit haz_chk_en = 1'b0;

   always #5 clk = ~clk;

   ie_operand_stage_reg dut (
      .clk                   (clk),
      .reset                 (reset),
      .stall_IE              (stall_IE),
      .flush_IE              (flush_IE),
      .valid_ID              (valid_ID),
      .inst_mem_addr_ID      (inst_mem_addr_ID),
      .rs1_value_ID          (rs1_value_ID),
      .rs1_addr_ID           (rs1_addr_ID),
      .rd_addr_ID            (rd_addr_ID),
      .reg_write_ID          (reg_write_ID),
      .mem_read_ID           (mem_read_ID),
      .use_pc_ID             (use_pc_ID),
      .ALU_out_IM_REG2       (ALU_out_IM_REG2),
`ifdef FWD_WB_EN
      .wb_reg_write          (wb_reg_write),
      .wb_rd_addr            (wb_rd_addr),
      .wb_value              (wb_value),
`endif
      .valid_IE_REG2         (valid_IE_REG2),
      .inst_mem_addr_IE_REG1 (inst_mem_addr_IE_REG1),
      .rs1_value_IE_REG2     (rs1_value_IE_REG2),
      .rd_addr_IE_REG2       (rd_addr_IE_REG2),
      .reg_write_IE_REG2     (reg_write_IE_REG2),
      .mem_read_IE_REG2      (mem_read_IE_REG2),
      .IE_mux1_SEL           (IE_mux1_SEL),
      .hazard_stall_req      (hazard_stall_req)
   );

   // Model of what IE holds; 'known' is cleared when a bubble makes the data
   // fields don't-care.
   typedef struct packed {
      bit        valid;
      bit [10:0] pc;
      bit [31:0] rs1;
      bit [4:0]  rd;
      bit        rw;
      bit        mr;
      bit [1:0]  sel;
      bit        known;
   } mstate_t;

   mstate_t m = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_haz();
      return valid_ID && m.valid && m.mr && (m.rd != 0) && (m.rd == rs1_addr_ID) && !use_pc_ID;
   endfunction

   function automatic mstate_t model_next(bit haz);
      mstate_t n = m;
      if (reset) begin
         n = '0;
         n.known = 1'b1;
      end else if (flush_IE || (!stall_IE && haz)) begin
         n.valid = 0; n.rw = 0; n.mr = 0; n.sel = 2'd0; n.known = 0;
      end else if (stall_IE) begin
         if (m.sel == 2'd2) begin
            n.rs1 = ALU_out_IM_REG2;
            n.sel = 2'd0;
         end
      end else begin
         n.valid = valid_ID;
         n.pc    = inst_mem_addr_ID;
         n.rd    = rd_addr_ID;
         n.rw    = reg_write_ID && valid_ID;
         n.mr    = mem_read_ID && valid_ID;
         n.known = 1'b1;
         if (use_pc_ID) n.sel = 2'd1;
         else if (m.valid && m.rw && (m.rd != 0) && (m.rd == rs1_addr_ID)) n.sel = 2'd2;
         else n.sel = 2'd0;
         n.rs1 = rs1_value_ID;
`ifdef FWD_WB_EN
         if (n.sel == 2'd0 && wb_reg_write && (wb_rd_addr != 0) && (wb_rd_addr == rs1_addr_ID))
            n.rs1 = wb_value;
`endif
      end
      return n;
   endfunction

   task automatic compare_outputs();
      check("valid", valid_IE_REG2, m.valid);
      check("reg_write", reg_write_IE_REG2, m.rw);
      check("mem_read", mem_read_IE_REG2, m.mr);
      check("sel", IE_mux1_SEL, m.sel);
      if (m.known) begin
         check("pc", inst_mem_addr_IE_REG1, m.pc);
         check("rs1_value", rs1_value_IE_REG2, m.rs1);
         check("rd", rd_addr_IE_REG2, m.rd);
      end
   endtask

   // One clock: check the combinational request, advance the model, then
   // check the registered outputs shortly after the edge.
   task automatic step();
      mstate_t nx;
      bit haz;
      #1;
      haz = model_haz();
      if (haz_chk_en) check("hazard", hazard_stall_req, haz);
      nx = model_next(haz);
      @(posedge clk);
      m = nx;
      #1;
      compare_outputs();
      haz_chk_en = 1'b1;
   endtask

   task automatic id(input bit v, input bit [10:0] pc, input bit [31:0] rv, input bit [4:0] ra,
                     input bit [4:0] rd, input bit rw, input bit mr, input bit up);
      valid_ID = v; inst_mem_addr_ID = pc; rs1_value_ID = rv; rs1_addr_ID = ra;
      rd_addr_ID = rd; reg_write_ID = rw; mem_read_ID = mr; use_pc_ID = up;
   endtask

   task automatic randomize_id();
      id(1'b1, 11'($urandom), $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
         1'($urandom), 1'($urandom), 1'($urandom));
      ALU_out_IM_REG2 = $urandom;
   endtask

   initial begin
      // Reset with random inputs; IE stays empty so no hazard can be raised.
      @(posedge clk); #1;
      reset = 1'b1;
      randomize_id(); step();
      randomize_id(); step();
      check("rst_hazard", hazard_stall_req, 1'b0);
      check("rst_rs1", rs1_value_IE_REG2, 32'h0);
      reset = 1'b0;

      // ADD x5 then SUB rs1=x5: forward from IM.
      id(1, 11'h010, 32'h111, 5'd1, 5'd5, 1, 0, 0); step();
      id(1, 11'h014, 32'h222, 5'd5, 5'd6, 1, 0, 0); step();
      check("add_fwd_sel", IE_mux1_SEL, 2'b10);

      // Producer writes x0: never forwards.
      id(1, 11'h018, 32'h0, 5'd0, 5'd0, 1, 0, 0); step();
      id(1, 11'h01C, 32'h333, 5'd0, 5'd3, 1, 0, 0); step();
      check("x0_sel", IE_mux1_SEL, 2'b00);

      // LW x7 then ADD rs1=x7: one-cycle stall request and bubble, then the
      // retried ADD loads behind the bubble.
      id(1, 11'h020, 32'h44, 5'd2, 5'd7, 1, 1, 0); step();
      id(1, 11'h024, 32'h55, 5'd7, 5'd8, 1, 0, 0);
      #1 check("lw_hazard", hazard_stall_req, 1'b1);
      step();
      check("lw_bubble", valid_IE_REG2, 1'b0);
      step();
      check("lw_retry_valid", valid_IE_REG2, 1'b1);
      check("lw_retry_hazard", hazard_stall_req, 1'b0);

      // AUIPC matching prior rd: PC wins.
      id(1, 11'h1A4, 32'h66, 5'd8, 5'd9, 1, 0, 1); step();
      check("auipc_sel", IE_mux1_SEL, 2'b01);
      check("auipc_pc", inst_mem_addr_IE_REG1, 11'h1A4);

      // Forward pending, then 3-cycle stall: capture on the first edge only.
      id(1, 11'h030, 32'h77, 5'd9, 5'd10, 1, 0, 0); step();
      check("pre_stall_sel", IE_mux1_SEL, 2'b10);
      stall_IE = 1'b1; ALU_out_IM_REG2 = 32'hDEADBEEF; step();
      check("cap_rs1", rs1_value_IE_REG2, 32'hDEADBEEF);
      check("cap_sel", IE_mux1_SEL, 2'b00);
      ALU_out_IM_REG2 = 32'h12345678; step(); step();
      check("cap_held", rs1_value_IE_REG2, 32'hDEADBEEF);
      stall_IE = 1'b0;

      // Reset in the middle of a stall with a pending forward.
      id(1, 11'h034, 32'h88, 5'd10, 5'd11, 1, 0, 0); step();
      stall_IE = 1'b1; step();
      reset = 1'b1; step();
      reset = 1'b0; stall_IE = 1'b0;
      check("rst_stall_sel", IE_mux1_SEL, 2'b00);
      check("rst_stall_valid", valid_IE_REG2, 1'b0);

      // Flush coinciding with a hazard: request still raised, bubble loaded.
      id(1, 11'h038, 32'h99, 5'd1, 5'd12, 1, 1, 0); step();
      id(1, 11'h03C, 32'hAA, 5'd12, 5'd13, 1, 0, 0);
      flush_IE = 1'b1;
      #1 check("flush_hazard", hazard_stall_req, 1'b1);
      step();
      check("flush_bubble", valid_IE_REG2, 1'b0);
      flush_IE = 1'b0;

`ifdef FWD_WB_EN
      // WB forward when IE holds nothing that matches.
      wb_reg_write = 1'b1; wb_rd_addr = 5'd9; wb_value = 32'h55;
      id(1, 11'h040, 32'hBB, 5'd9, 5'd13, 1, 0, 0); step();
      check("wb_rs1", rs1_value_IE_REG2, 32'h55);
      // Same WB match while the IM producer also matches: IM wins.
      wb_rd_addr = 5'd13;
      id(1, 11'h044, 32'hCC, 5'd13, 5'd14, 1, 0, 0); step();
      check("wb_im_sel", IE_mux1_SEL, 2'b10);
      wb_reg_write = 1'b0;
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         randomize_id();
         valid_ID = ($urandom_range(0, 7) != 0);
         use_pc_ID = ($urandom_range(0, 7) == 0);
         stall_IE = ($urandom_range(0, 5) == 0);
         flush_IE = ($urandom_range(0, 9) == 0);
         reset = ($urandom_range(0, 49) == 0);
         wb_reg_write = 1'($urandom);
         wb_rd_addr = 5'($urandom_range(0, 3));
         wb_value = $urandom;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
